// File: rtl/dino_pkg.sv
// Shared constants for the dino game blocks: FSM encoding, LFSR seed/taps,
// and the spawn/player geometry the controller and obstacle engine agree on.
package dino_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    CRASHED = 1'b1
  } state_e;

  // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int DEF_GEN_LINE      = 250;
  localparam int DEF_PLAYER_OFFSET = 6;

  localparam int NUM_SLOTS = 2;
  localparam int SPEED_W   = 4;
  localparam int SPEED_MAX = 8;
  localparam int TIMER_W   = 8;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; seeded nonzero so it never locks at zero.
module lfsr16
  import dino_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] out
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;

endmodule

// File: rtl/obstacle_engine.sv
// Two-slot obstacle spawner/scroller with collision detect and crash/restart FSM.
// Optional OBSTACLE_SPEEDUP_EN: speed +1 every 512 run frames, capped at 8.
module obstacle_engine
  import dino_pkg::*;
#(
  parameter int CONV          = 0,
  parameter int GEN_LINE      = DEF_GEN_LINE,
  parameter int PLAYER_OFFSET = DEF_PLAYER_OFFSET,
  parameter int HIT_W         = 4,
  parameter int OBST_H        = 12,
  parameter int SPEED_INIT    = 2,
  parameter int MIN_GAP       = 40
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           frame_tick,
  input  logic [7:0]     player_y,
  input  logic           button_up,
  output logic [9:CONV]  obstacle1_pos,
  output logic [9:CONV]  obstacle2_pos,
  output logic           crash,
  output logic [15:0]    score
);

  localparam int W      = 10 - CONV;
  localparam int HIT_LO = PLAYER_OFFSET - HIT_W;

  state_e                        state_q, state_d;
  logic [NUM_SLOTS-1:0][W-1:0]   pos_q, pos_d, moved;
  logic [NUM_SLOTS-1:0]          in_win, free;
  logic [SPEED_W-1:0]            speed_q, speed_d;
  logic [TIMER_W-1:0]            timer_q, timer_d;
  logic [15:0]                   score_q, score_d;
  logic [15:0]                   lfsr;
  logic                          hit_now, run_tick, restart, spawn_done;
  logic                          unused_lfsr_hi;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (lfsr)
  );
  assign unused_lfsr_hi = ^lfsr[15:6];

  // Per-slot move (clamped at 0 = despawn) and collision window.
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign moved[i]  = (pos_q[i] > W'(speed_q)) ? pos_q[i] - W'(speed_q) : '0;
    assign free[i]   = (moved[i] == '0);
    assign in_win[i] = (pos_q[i] != '0) && (int'(pos_q[i]) > HIT_LO) &&
                       (int'(pos_q[i]) <= PLAYER_OFFSET);
  end

  assign hit_now  = (state_q == RUN) && (|in_win) && (player_y < 8'(OBST_H));
  assign run_tick = (state_q == RUN) && frame_tick;
  assign restart  = (state_q == CRASHED) && button_up;

  // FSM: state register / next state / outputs
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (hit_now) state_d = CRASHED;
      CRASHED: if (button_up) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    crash = (state_q == CRASHED);
  end

  // Frame update: move, timer, spawn into lowest free slot, score.
  always_comb begin
    pos_d      = pos_q;
    timer_d    = timer_q;
    score_d    = score_q;
    spawn_done = 1'b0;
    if (restart) begin
      pos_d   = '0;
      timer_d = TIMER_W'(MIN_GAP);
      score_d = '0;
    end else if (run_tick) begin
      pos_d = moved;
      if (timer_q != '0) begin
        timer_d = timer_q - 1'b1;
      end else begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (!spawn_done && free[i]) begin
            pos_d[i]   = W'(GEN_LINE);
            spawn_done = 1'b1;
          end
        end
        // With no free slot the timer stays at 0 so the spawn retries next tick.
        if (spawn_done) timer_d = TIMER_W'(MIN_GAP) + TIMER_W'(lfsr[5:0]);
      end
      if (score_q != '1) score_d = score_q + 1'b1;
    end
  end

`ifdef OBSTACLE_SPEEDUP_EN
  logic [8:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    speed_d     = speed_q;
    frame_cnt_d = frame_cnt_q;
    if (restart) begin
      speed_d     = SPEED_W'(SPEED_INIT);
      frame_cnt_d = '0;
    end else if (run_tick) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
      if (frame_cnt_q == '1 && speed_q < SPEED_W'(SPEED_MAX)) speed_d = speed_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end
`else
  always_comb speed_d = SPEED_W'(SPEED_INIT);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_q   <= '0;
      timer_q <= TIMER_W'(MIN_GAP);
      score_q <= '0;
      speed_q <= SPEED_W'(SPEED_INIT);
    end else begin
      pos_q   <= pos_d;
      timer_q <= timer_d;
      score_q <= score_d;
      speed_q <= speed_d;
    end
  end

  assign obstacle1_pos = pos_q[0];
  assign obstacle2_pos = pos_q[1];
  assign score         = score_q;

endmodule

// File: tb/tb_obstacle_engine.sv
// Bench for obstacle_engine: cycle scoreboard against a behavioural model,
// a table of hand-derived checkpoints, and hand sequences for crash/restart.
module tb_obstacle_engine;

  localparam int GEN = 250, PO = 6, HW = 4, OH = 12, SI = 2, MG = 40;

  logic       clk = 1'b0;
  logic       rst_n, frame_tick, button_up;
  logic [7:0] player_y;
  logic [9:0] p1, p2;
  logic       crash;
  logic [15:0] score;

  always #5 clk = ~clk;

  obstacle_engine dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .player_y      (player_y),
    .button_up     (button_up),
    .obstacle1_pos (p1),
    .obstacle2_pos (p2),
    .crash         (crash),
    .score         (score)
  );

  typedef struct {int p1; int p2; int crash; int score;} exp_t;
  typedef struct {int n; int py; int p1; int p2; int crash; int score;} vec_t;

  exp_t sbq[$];
  int   n_checks = 0, n_err = 0;

  // behavioural model state
  int          m_crashed, m_score, m_timer, m_runticks;
  int          m_pos[2];
  logic [15:0] m_lfsr;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int m_speed();
`ifdef OBSTACLE_SPEEDUP_EN
    int s;
    s = SI + m_runticks / 512;
    return (s > 8) ? 8 : s;
`else
    return SI;
`endif
  endfunction

  task automatic model_edge(input bit r, input bit t, input int py, input bit b);
    logic [15:0] nl;
    bit hit, placed;
    int sp;
    if (!r) begin
      m_crashed = 0; m_score = 0; m_timer = MG; m_runticks = 0;
      m_pos[0] = 0; m_pos[1] = 0; m_lfsr = 16'hACE1;
      return;
    end
    nl = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    if (m_crashed == 0) begin
      hit = 0;
      for (int k = 0; k < 2; k++)
        if (m_pos[k] != 0 && m_pos[k] > PO - HW && m_pos[k] <= PO && py < OH) hit = 1;
      if (t) begin
        sp = m_speed();
        for (int k = 0; k < 2; k++) m_pos[k] = (m_pos[k] > sp) ? m_pos[k] - sp : 0;
        if (m_timer == 0) begin
          placed = 0;
          for (int k = 0; k < 2; k++)
            if (!placed && m_pos[k] == 0) begin m_pos[k] = GEN; placed = 1; end
          if (placed) m_timer = MG + int'(m_lfsr[5:0]);
        end else m_timer--;
        if (m_score < 65535) m_score++;
        m_runticks++;
      end
      if (hit) m_crashed = 1;
    end else if (b) begin
      m_crashed = 0; m_score = 0; m_timer = MG; m_runticks = 0;
      m_pos[0] = 0; m_pos[1] = 0;
    end
    m_lfsr = nl;
  endtask

  task automatic step(input bit t, input int py, input bit b, input bit r = 1'b1);
    exp_t e;
    rst_n = r; frame_tick = t; player_y = 8'(py); button_up = b;
    model_edge(r, t, py, b);
    sbq.push_back('{m_pos[0], m_pos[1], m_crashed, m_score});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("sb_pos1",  int'(p1),    e.p1);
    chk("sb_pos2",  int'(p2),    e.p2);
    chk("sb_crash", int'(crash), e.crash);
    chk("sb_score", int'(score), e.score);
  endtask

  task automatic tick(input int py);
    step(1'b1, py, 1'b0);
    step(1'b0, py, 1'b0);
  endtask

  task automatic ticks(input int n, input int py);
    for (int i = 0; i < n; i++) tick(py);
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{40, 20,   0, 0, 0, 40};
    tbl[1] = '{ 1, 20, 250, 0, 0, 41};
    tbl[2] = '{ 1, 20, 248, 0, 0, 42};
    tbl[3] = '{10, 20, 228, 0, 0, 52};
    tbl[4] = '{28, 20, 172, 0, 0, 80};

    // reset state
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b0);
    chk("rst_pos1", int'(p1), 0);
    chk("rst_pos2", int'(p2), 0);
    chk("rst_crash", int'(crash), 0);
    chk("rst_score", int'(score), 0);

    // first spawn exactly on tick 41, then scroll at speed 2
    for (int v = 0; v < 5; v++) begin
      ticks(tbl[v].n, tbl[v].py);
      chk($sformatf("tbl%0d_pos1", v),  int'(p1),    tbl[v].p1);
      chk($sformatf("tbl%0d_pos2", v),  int'(p2),    tbl[v].p2);
      chk($sformatf("tbl%0d_crash", v), int'(crash), tbl[v].crash);
      chk($sformatf("tbl%0d_score", v), int'(score), tbl[v].score);
    end

    // grounded player meets slot 1 in the window: crash one cycle later, then freeze
    ticks(81, 20);
    chk("pre_hit_pos1", int'(p1), 10);
    tick(0);
    step(1'b1, 0, 1'b0);
    chk("hit_pos1", int'(p1), 6);
    chk("hit_crash_early", int'(crash), 0);
    step(1'b0, 0, 1'b0);
    chk("hit_crash", int'(crash), 1);
    ticks(20, 0);
    chk("frozen_pos1", int'(p1), 6);
    chk("frozen_score", int'(score), 163);
    chk("frozen_crash", int'(crash), 1);

    // restart with frame_tick and button_up together
    step(1'b1, 0, 1'b1);
    chk("rs_crash", int'(crash), 0);
    chk("rs_pos1", int'(p1), 0);
    chk("rs_pos2", int'(p2), 0);
    chk("rs_score", int'(score), 0);
    ticks(40, 15);
    chk("rs_nospawn", int'(p1), 0);
    tick(15);
    chk("rs_spawn", int'(p1), 250);

    // jumping player passes the window; slot 1 despawns (or is refilled same tick)
    ticks(122, 15);
    chk("jump_pos1", int'(p1), 6);
    chk("jump_crash", int'(crash), 0);
    ticks(2, 15);
    chk("jump_pos1_2", int'(p1), 2);
    tick(15);
    chk("despawn_0_or_respawn", int'(p1 == 10'd0 || p1 == 10'd250), 1);
    chk("jump_score", int'(score), 166);

    // long run: blocked spawns and same-tick refills are covered by the scoreboard
    ticks(1000, 20);

    // reset mid-game
    step(1'b0, 20, 1'b0, 1'b0);
    chk("mid_rst_pos1", int'(p1), 0);
    chk("mid_rst_pos2", int'(p2), 0);
    chk("mid_rst_score", int'(score), 0);
    chk("mid_rst_crash", int'(crash), 0);

`ifdef OBSTACLE_SPEEDUP_EN
    begin
      int prev, done_n;
      bit found;
      ticks(520, 20);
      done_n = 520;
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
        prev = int'(p1); tick(20); done_n++;
        if (prev > 8 && int'(p1) != GEN) begin chk("speed3", prev - int'(p1), 3); found = 1; end
      end
      if (!found) chk("speed3_sample", 0, 1);
      ticks(3080 - done_n, 20);
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
        prev = int'(p1); tick(20);
        if (prev > 8 && int'(p1) != GEN) begin chk("speed8", prev - int'(p1), 8); found = 1; end
      end
      if (!found) chk("speed8_sample", 0, 1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
